alu_issue_stage: RTL and testbench

- Producer side of the MIPS150 ALU interface.
- Accepts one instruction per handshake, together with its register-file operands (rs, rt).
- Decodes opcode/funct into the 4-bit ALUop and forms the ALU A/B operands, including the shift-amount and immediate-extension rules the ALU expects.
- Presents the result through a registered valid/ready output stage with a one-entry skid buffer. Sits between register read and the ALU.

---
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage between register read and the MIPS150 ALU: decodes the instruction into
// ALUop plus A/B operands and presents the result through a registered valid/ready stage.
module alu_issue_stage #(
  parameter bit SKID = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_aluop,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_LUI  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_NOR  = 4'd11,
    ALU_XXX  = 4'd15
  } aluop_e;

  typedef enum logic [2:0] {
    OPD_NONE,
    OPD_RS_RT,
    OPD_SHAMT_RT,
    OPD_RS_SEXT,
    OPD_RS_ZEXT,
    OPD_ZERO_ZEXT
  } opd_e;

  typedef struct packed {
    logic        illegal;
    aluop_e      aluop;
    logic [31:0] a;
    logic [31:0] b;
  } bundle_t;

  localparam bundle_t RESET_BUNDLE = '{illegal: 1'b0, aluop: ALU_XXX, a: '0, b: '0};

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        unused_instr_bits;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign imm    = in_instr[15:0];
  assign shamt  = in_instr[10:6];
  assign unused_instr_bits = ^in_instr[25:16];

  aluop_e  dec_op;
  opd_e    dec_opd;
  bundle_t dec;

  // NOTE: every variable written in a combinational block gets a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    dec_op  = ALU_XXX;
    dec_opd = OPD_NONE;
    case (opcode)
      6'h00: begin
        dec_opd = OPD_RS_RT;
        case (funct)
          6'h21: dec_op = ALU_ADDU;
          6'h23: dec_op = ALU_SUBU;
          6'h24: dec_op = ALU_AND;
          6'h25: dec_op = ALU_OR;
          6'h26: dec_op = ALU_XOR;
          6'h27: dec_op = ALU_NOR;
          6'h2A: dec_op = ALU_SLT;
          6'h2B: dec_op = ALU_SLTU;
          6'h00: begin dec_op = ALU_SLL; dec_opd = OPD_SHAMT_RT; end
          6'h02: begin dec_op = ALU_SRL; dec_opd = OPD_SHAMT_RT; end
          6'h03: begin dec_op = ALU_SRA; dec_opd = OPD_SHAMT_RT; end
          6'h04: dec_op = ALU_SLL;
          6'h06: dec_op = ALU_SRL;
          6'h07: dec_op = ALU_SRA;
          default: dec_opd = OPD_NONE;
        endcase
      end
      6'h09: begin dec_op = ALU_ADDU; dec_opd = OPD_RS_SEXT;   end
      6'h0A: begin dec_op = ALU_SLT;  dec_opd = OPD_RS_SEXT;   end
      6'h0B: begin dec_op = ALU_SLTU; dec_opd = OPD_RS_SEXT;   end
      6'h0C: begin dec_op = ALU_AND;  dec_opd = OPD_RS_ZEXT;   end
      6'h0D: begin dec_op = ALU_OR;   dec_opd = OPD_RS_ZEXT;   end
      6'h0E: begin dec_op = ALU_XOR;  dec_opd = OPD_RS_ZEXT;   end
      6'h0F: begin dec_op = ALU_LUI;  dec_opd = OPD_ZERO_ZEXT; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: begin
        dec_op  = ALU_ADDU;
        dec_opd = OPD_RS_SEXT;
      end
      default: dec_opd = OPD_NONE;
    endcase
  end

  // Anything the ALU does not handle still issues, with zeroed operands and XXX.
  always_comb begin
    dec = '{illegal: 1'b0, aluop: dec_op, a: '0, b: '0};
    case (dec_opd)
      OPD_RS_RT:     begin dec.a = in_rs_data;         dec.b = in_rt_data;               end
      OPD_SHAMT_RT:  begin dec.a = {27'b0, shamt};     dec.b = in_rt_data;               end
      OPD_RS_SEXT:   begin dec.a = in_rs_data;         dec.b = {{16{imm[15]}}, imm};     end
      OPD_RS_ZEXT:   begin dec.a = in_rs_data;         dec.b = {16'b0, imm};             end
      OPD_ZERO_ZEXT: begin dec.a = '0;                 dec.b = {16'b0, imm};             end
      default:       begin dec.illegal = 1'b1;         dec.aluop = ALU_XXX;              end
    endcase
  end

  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_fire, out_free;

  assign in_ready = SKID ? ~skid_valid_q : (out_ready | ~out_valid_q);
  assign in_fire  = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  // The skid entry is only ever filled while the output is stalled, and always drains
  // first when the output frees, which keeps the stream in order.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (SKID && in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the data registers are reset too because their reset values are visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= RESET_BUNDLE;
      out_valid_q  <= 1'b0;
      skid_q       <= RESET_BUNDLE;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_aluop   = out_q.aluop;
  assign out_a       = out_q.a;
  assign out_b       = out_q.b;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage: decode cases, backpressure ordering
// through the skid entry, and asynchronous reset during a full stall.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluop;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;

  int n_checks = 0;
  int n_passed = 0;
  logic [31:0] seen_a[$];

  alu_issue_stage #(.SKID(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluop   (out_aluop),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Record operand A of every output transfer to check stream order.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) seen_a.push_back(out_a);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_passed++;
  endtask

  task automatic run_one(input string tag, input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [3:0] exp_op,
                         input logic [31:0] exp_a, input logic [31:0] exp_b,
                         input logic exp_ill);
    @(negedge clk);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_rs_data = rs;
    in_rt_data = rt;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_rs_data = 32'hDEAD_BEEF;
    in_rt_data = 32'hCAFE_F00D;
    #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_op"}, {28'b0, out_aluop}, {28'b0, exp_op});
    check({tag, "_a"}, out_a, exp_a);
    check({tag, "_b"}, out_b, exp_b);
    check({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, exp_ill});
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_rs_data = rs;
    in_rt_data = 32'h0000_0001;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic z_taken;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs_data = '0;
    in_rt_data = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_op", {28'b0, out_aluop}, 32'd15);
    check("rst_a", out_a, 32'd0);
    check("rst_ill", {31'b0, out_illegal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_valid", {31'b0, out_valid}, 32'd0);
    check("idle_op", {28'b0, out_aluop}, 32'd15);

    run_one("addu",  32'h0043_0821, 32'd5,         32'd7,         4'd0,  32'd5,         32'd7,         1'b0);
    run_one("sll",   32'h0002_0900, 32'h1111_1111, 32'h0000_0001, 4'd8,  32'd4,         32'd1,         1'b0);
    run_one("srav",  32'h0043_0807, 32'h0000_0025, 32'h8000_0000, 4'd10, 32'h0000_0025, 32'h8000_0000, 1'b0);
    run_one("addiu", 32'h2441_FFF0, 32'h0000_0010, 32'h0,         4'd0,  32'h0000_0010, 32'hFFFF_FFF0, 1'b0);
    run_one("ori",   32'h3441_FFF0, 32'h0000_0003, 32'h0,         4'd5,  32'h0000_0003, 32'h0000_FFF0, 1'b0);
    run_one("lui",   32'h3C01_1234, 32'h5555_5555, 32'h0,         4'd7,  32'h0,         32'h0000_1234, 1'b0);
    run_one("lw",    32'h8C41_FF00, 32'h0000_1000, 32'h0,         4'd0,  32'h0000_1000, 32'hFFFF_FF00, 1'b0);
    run_one("sltiu", 32'h2C41_8000, 32'h0000_0042, 32'h0,         4'd3,  32'h0000_0042, 32'hFFFF_8000, 1'b0);
    run_one("illop", 32'hFC00_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0,         32'h0,         1'b1);
    run_one("illfn", 32'h0043_0801, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0,         32'h0,         1'b1);

    // Backpressure: X on the output, Y in the skid entry, Z waits.
    repeat (2) @(negedge clk);
    seen_a.delete();
    out_ready = 1'b0;
    drive(32'h0043_0821, 32'h0000_00A1);
    @(negedge clk);
    drive(32'h0043_0823, 32'h0000_00B2);
    @(negedge clk);
    check("bp_ready_after_y", {31'b0, in_ready}, 32'd0);
    drive(32'h0043_0824, 32'h0000_00C3);
    repeat (2) @(negedge clk);
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold_a", out_a, 32'h0000_00A1);
    check("bp_hold_op", {28'b0, out_aluop}, 32'd0);
    check("bp_z_blocked", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    z_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        z_taken = 1'b1;
        break;
      end
    end
    check("bp_z_taken", {31'b0, z_taken}, 32'd1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_count", seen_a.size(), 32'd3);
    if (seen_a.size() == 3) begin
      check("bp_order_x", seen_a[0], 32'h0000_00A1);
      check("bp_order_y", seen_a[1], 32'h0000_00B2);
      check("bp_order_z", seen_a[2], 32'h0000_00C3);
    end
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while output and skid are both full.
    out_ready = 1'b0;
    drive(32'h0043_0821, 32'h0000_0D01);
    @(negedge clk);
    drive(32'h0043_0821, 32'h0000_0D02);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_full_ready", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_op", {28'b0, out_aluop}, 32'd15);
    @(negedge clk);
    rst = 1'b0;
    seen_a.delete();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_no_stale", seen_a.size(), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
